// File: rtl/cache_i_pkg.sv
// Shared types and constants for the N-way instruction cache.
package cache_i_pkg;

    localparam int unsigned LINE_W         = 128;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;

    typedef enum logic {
        StIdle,
        StRefill
    } state_e;

    // Tree-PLRU bits needed per set for a given associativity.
    function automatic int unsigned plru_width(input int unsigned ways);
        if (ways >= 4) return 3;
        if (ways == 2) return 1;
        return 0;
    endfunction

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        off);
        logic [WORD_W-1:0] w;
        unique case (off)
            2'd0:    w = line[WORD_W-1:0];
            2'd1:    w = line[2*WORD_W-1:WORD_W];
            2'd2:    w = line[3*WORD_W-1:2*WORD_W];
            default: w = line[4*WORD_W-1:3*WORD_W];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set victim choice (lowest invalid way, else tree-PLRU) and PLRU update on access.
module cache_plru
    import cache_i_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned WAY_W    = 1,
    parameter int unsigned PLRU_W   = 1
) (
    input  logic [PLRU_W-1:0]   plru_i,
    input  logic [NUM_WAYS-1:0] valid_i,
    input  logic [WAY_W-1:0]    access_way_i,
    output logic [WAY_W-1:0]    victim_o,
    output logic [PLRU_W-1:0]   plru_o
);

    logic [WAY_W-1:0] plru_victim;

    if (NUM_WAYS == 4) begin : g_four
        always_comb begin
            plru_victim = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
            plru_o      = plru_i;
            // Point every bit on the accessed way's path away from it.
            unique case (access_way_i)
                2'd0: begin plru_o[0] = 1'b1; plru_o[1] = 1'b1; end
                2'd1: begin plru_o[0] = 1'b1; plru_o[1] = 1'b0; end
                2'd2: begin plru_o[0] = 1'b0; plru_o[2] = 1'b1; end
                default: begin plru_o[0] = 1'b0; plru_o[2] = 1'b0; end
            endcase
        end
    end else if (NUM_WAYS == 2) begin : g_two
        always_comb begin
            plru_victim = plru_i[0];
            plru_o      = ~access_way_i;
        end
    end else begin : g_one
        logic unused_way;
        assign unused_way  = ^access_way_i;
        assign plru_victim = '0;
        assign plru_o      = plru_i;
    end

    always_comb begin
        victim_o = plru_victim;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_i[w]) victim_o = WAY_W'(w);
        end
    end

endmodule

// File: rtl/cache_i_nway.sv
// Read-only N-way set-associative I-cache with critical-word forwarding, flush and counters.
module cache_i_nway
    import cache_i_pkg::*;
#(
    parameter int unsigned NUM_SETS = 4,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [29:0]       proc_addr,
    input  logic [WORD_W-1:0] proc_wdata,
    output logic [WORD_W-1:0] proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [27:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = 28 - IDX_W;
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned PLRU_W = (plru_width(NUM_WAYS) == 0) ? 1 : plru_width(NUM_WAYS);

    state_e            state_q, state_d;
    logic              flush_pend_q, flush_pend_d;
    logic              mem_read_q, mem_read_d;
    logic [TAG_W-1:0]  tag_lat_q;
    logic [IDX_W-1:0]  idx_lat_q;
    logic [1:0]        off_lat_q;
    logic [WAY_W-1:0]  vic_lat_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [PLRU_W-1:0]   plru_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   line_q  [NUM_SETS][NUM_WAYS];

    logic [1:0]        req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WORD_W-1:0] hit_word, fill_word;
    logic              flush_now;
    logic              do_hit, do_miss, do_fill, do_flush;

    logic [IDX_W-1:0]  plru_set;
    logic [WAY_W-1:0]  plru_way, victim;
    logic [PLRU_W-1:0] plru_upd;

    logic unused_write;
    assign unused_write = proc_write ^ (^proc_wdata);

    assign req_off = proc_addr[1:0];
    assign req_idx = proc_addr[IDX_W+1:2];
    assign req_tag = proc_addr[29:IDX_W+2];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_word  = line_word(line_q[req_idx][hit_way], req_off);
    assign fill_word = line_word(mem_rdata, off_lat_q);
    assign flush_now = flush || flush_pend_q;

    // One PLRU datapath: lookup set in IDLE, latched refill set in REFILL.
    assign plru_set = (state_q == StRefill) ? idx_lat_q : req_idx;
    assign plru_way = (state_q == StRefill) ? vic_lat_q : hit_way;

    cache_plru #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W),
        .PLRU_W   (PLRU_W)
    ) u_plru (
        .plru_i       (plru_q[plru_set]),
        .valid_i      (valid_q[plru_set]),
        .access_way_i (plru_way),
        .victim_o     (victim),
        .plru_o       (plru_upd)
    );

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        mem_read_d   = mem_read_q;
        do_hit       = 1'b0;
        do_miss      = 1'b0;
        do_fill      = 1'b0;
        do_flush     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_now) begin
                    do_flush     = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (proc_read) begin
                    if (hit) begin
                        do_hit = 1'b1;
                    end else begin
                        do_miss    = 1'b1;
                        mem_read_d = 1'b1;
                        state_d    = StRefill;
                    end
                end
            end
            StRefill: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_ready) begin
                    do_fill    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        proc_rdata = '0;
        proc_stall = 1'b0;
        mem_addr   = proc_addr[29:2];
        unique case (state_q)
            StIdle: begin
                if (flush_now) begin
                    proc_stall = 1'b1;
                end else if (proc_read) begin
                    if (hit) proc_rdata = hit_word;
                    else     proc_stall = 1'b1;
                end
            end
            StRefill: begin
                mem_addr = {tag_lat_q, idx_lat_q};
                if (mem_ready) proc_rdata = fill_word;
                else           proc_stall = 1'b1;
            end
        endcase
    end

    assign mem_read  = mem_read_q;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            mem_read_q   <= 1'b0;
            tag_lat_q    <= '0;
            idx_lat_q    <= '0;
            off_lat_q    <= '0;
            vic_lat_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            mem_read_q   <= mem_read_d;
            if (do_miss) begin
                tag_lat_q <= req_tag;
                idx_lat_q <= req_idx;
                off_lat_q <= req_off;
                vic_lat_q <= victim;
            end
            if (do_flush) begin
                for (int s = 0; s < int'(NUM_SETS); s++) valid_q[s] <= '0;
            end
            if (do_fill) valid_q[idx_lat_q][vic_lat_q] <= 1'b1;
            if (do_hit || do_fill) plru_q[plru_set] <= plru_upd;
            if (do_hit && (hit_cnt_q != {CNT_W{1'b1}})) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (do_miss && (miss_cnt_q != {CNT_W{1'b1}})) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_q[idx_lat_q][vic_lat_q]  <= tag_lat_q;
            line_q[idx_lat_q][vic_lat_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_i_nway.sv
// Scoreboard bench: a 2-way/CNT_W=4 and a 4-way instance share stimulus; sel picks the checked one.
module tb_cache_i_nway;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        bit          hit;
        int          delay;
    } exp_t;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b1;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = 32'hDEADBEEF;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         flush_drv = 1'b0;
    logic         flush_rsp = 1'b0;
    logic         flush;

    logic [31:0]  rdata2, rdata4;
    logic         stall2, stall4, mrd2, mrd4, mwr2, mwr4;
    logic [27:0]  maddr2, maddr4;
    logic [127:0] mwdata2, mwdata4;
    logic [3:0]   hcnt2, mcnt2;
    logic [31:0]  hcnt4, mcnt4;

    logic         sel = 1'b0;
    logic [31:0]  rdata_s, hcnt_s, mcnt_s;
    logic         stall_s, mrd_s;
    logic [27:0]  maddr_s;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   rdy_delay = 1;
    bit   rsp_en = 1'b1;
    bit   flush_mid = 1'b0;

    assign flush   = flush_drv | flush_rsp;
    assign rdata_s = sel ? rdata4 : rdata2;
    assign stall_s = sel ? stall4 : stall2;
    assign mrd_s   = sel ? mrd4 : mrd2;
    assign maddr_s = sel ? maddr4 : maddr2;
    assign hcnt_s  = sel ? hcnt4 : 32'(hcnt2);
    assign mcnt_s  = sel ? mcnt4 : 32'(mcnt2);

    always #5 clk = ~clk;

    cache_i_nway #(.NUM_SETS(4), .NUM_WAYS(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(rdata2), .proc_stall(stall2),
        .mem_read(mrd2), .mem_write(mwr2), .mem_addr(maddr2), .mem_wdata(mwdata2),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .flush(flush),
        .hit_cnt(hcnt2), .miss_cnt(mcnt2)
    );

    cache_i_nway #(.NUM_SETS(4), .NUM_WAYS(4), .CNT_W(32)) u_dut4 (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(rdata4), .proc_stall(stall4),
        .mem_read(mrd4), .mem_write(mwr4), .mem_addr(maddr4), .mem_wdata(mwdata4),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .flush(flush),
        .hit_cnt(hcnt4), .miss_cnt(mcnt4)
    );

    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        if (la == 28'h4) return 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = {la[23:0], 8'(k)};
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [29:0] a);
        logic [127:0] l;
        l = line_of(a[29:2]);
        return l[32*int'(a[1:0]) +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        proc_read  = 1'b0;
        proc_reset = 1'b1;
        @(posedge clk); #1;
        proc_reset = 1'b0;
    endtask

    task automatic fetch(input logic [29:0] a, input logic [31:0] d, input bit h, input int dly);
        exp_t e;
        int   n;
        e.addr = a; e.data = d; e.hit = h; e.delay = dly;
        exp_q.push_back(e);
        rdy_delay = dly;
        proc_addr = a;
        proc_read = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_s && n < 40);
        if (stall_s) begin
            n_cmp++;
            n_err++;
            $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles, required delivery",
                     a, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_chk(input string name, input logic exp_stall);
        proc_read = 1'b0;
        @(negedge clk);
        chk(name, 32'(stall_s), 32'(exp_stall));
        chk({name, "_mem_addr"}, 32'(maddr_s), 32'(proc_addr[29:2]));
        @(posedge clk); #1;
    endtask

    task automatic flush_idle();
        flush_drv = 1'b1;
        idle_chk("flush_stall", 1'b1);
        flush_drv = 1'b0;
    endtask

    task automatic chk_cnt(input string name, input int h, input int m);
        chk({name, "_hit_cnt"}, hcnt_s, 32'(h));
        chk({name, "_miss_cnt"}, mcnt_s, 32'(m));
    endtask

    // Monitor: pops an expected fetch whenever the checked DUT delivers a word.
    initial begin : monitor
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!proc_read || proc_reset) begin
                stall_cnt = 0;
            end else begin
                if (stall_cnt == 1) chk("mem_read_after_miss", 32'(mrd_s), 32'd1);
                if (stall_s) begin
                    if (stall_cnt == 0) chk("mem_read_on_detect", 32'(mrd_s), 32'd0);
                    stall_cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_delivery: got %h, required no delivery", rdata_s);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", rdata_s, e.data);
                        chk("hit", 32'(stall_cnt == 0), 32'(e.hit));
                        if (!e.hit) chk("stall_cycles", 32'(stall_cnt), 32'(e.delay));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Memory responder: answers a refill rdy_delay cycles after mem_read rises.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            flush_rsp = 1'b0;
            if (rsp_en && mrd_s) begin
                cnt++;
                if (cnt == 1) begin
                    if (exp_q.size() > 0) chk("mem_addr", 32'(maddr_s), 32'(exp_q[0].addr[29:2]));
                    if (flush_mid) flush_rsp = 1'b1;
                end
                if (cnt == rdy_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = line_of(maddr_s);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [29:0] hit_addrs [8];
        int          n;
        hit_addrs = '{30'h10, 30'h11, 30'h12, 30'h13, 30'h20, 30'h23, 30'h14, 30'h17};

        // 2-way: reset, cold miss, LRU replacement
        sel = 1'b0;
        do_reset();
        chk_cnt("reset", 0, 0);
        idle_chk("idle_no_read_stall", 1'b0);
        chk("mem_write_tied", 32'(mwr2), 32'd0);
        fetch(30'h10, 32'hAAAA0000, 1'b0, 3);
        fetch(30'h12, 32'hCCCC0002, 1'b1, 0);
        fetch(30'h20, word_of(30'h20), 1'b0, 1);
        fetch(30'h11, 32'hBBBB0001, 1'b1, 0);
        fetch(30'h30, word_of(30'h30), 1'b0, 2);
        fetch(30'h13, 32'hDDDD0003, 1'b1, 0);
        fetch(30'h20, word_of(30'h20), 1'b0, 1);
        chk_cnt("lru2", 3, 4);

        // flush in IDLE, then flush during a refill
        flush_idle();
        fetch(30'h13, 32'hDDDD0003, 1'b0, 2);
        flush_mid = 1'b1;
        fetch(30'h21, word_of(30'h21), 1'b0, 3);
        flush_mid = 1'b0;
        idle_chk("pending_flush_stall", 1'b1);
        fetch(30'h21, word_of(30'h21), 1'b0, 1);
        chk_cnt("flush2", 3, 7);

        // saturating counters on CNT_W=4
        do_reset();
        fetch(30'h10, 32'hAAAA0000, 1'b0, 1);
        fetch(30'h20, word_of(30'h20), 1'b0, 1);
        fetch(30'h14, word_of(30'h14), 1'b0, 1);
        for (int i = 0; i < 10; i++) fetch(hit_addrs[i % 8], word_of(hit_addrs[i % 8]), 1'b1, 0);
        chk_cnt("cnt10", 10, 3);
        for (int i = 0; i < 10; i++) fetch(hit_addrs[i % 8], word_of(hit_addrs[i % 8]), 1'b1, 0);
        chk_cnt("cnt_sat", 15, 3);

        // reset while a refill is outstanding
        rsp_en    = 1'b0;
        proc_addr = 30'h18;
        proc_read = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mrd_s && n < 10);
        chk("mem_read_before_reset", 32'(mrd_s), 32'd1);
        proc_reset = 1'b1;
        #1;
        chk("reset_mem_read", 32'(mrd_s), 32'd0);
        chk("reset_stall_on_miss", 32'(stall_s), 32'd1);
        chk_cnt("reset_mid", 0, 0);
        proc_read = 1'b0;
        @(posedge clk); #1;
        proc_reset = 1'b0;
        rsp_en     = 1'b1;
        fetch(30'h14, word_of(30'h14), 1'b0, 1);
        chk_cnt("after_reset", 0, 1);

        // 4-way tree-PLRU
        sel = 1'b1;
        do_reset();
        fetch(30'h10, 32'hAAAA0000, 1'b0, 1);
        fetch(30'h20, word_of(30'h20), 1'b0, 1);
        fetch(30'h30, word_of(30'h30), 1'b0, 1);
        fetch(30'h40, word_of(30'h40), 1'b0, 1);
        fetch(30'h10, 32'hAAAA0000, 1'b1, 0);
        fetch(30'h30, word_of(30'h30), 1'b1, 0);
        fetch(30'h50, word_of(30'h50), 1'b0, 2);
        fetch(30'h11, 32'hBBBB0001, 1'b1, 0);
        fetch(30'h32, word_of(30'h32), 1'b1, 0);
        fetch(30'h43, word_of(30'h43), 1'b1, 0);
        fetch(30'h20, word_of(30'h20), 1'b0, 1);
        chk_cnt("plru4", 5, 6);

        proc_read = 1'b0;
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
